// File: rtl/router_pkg.sv
// Constants shared by the router register stage, controller FSM and per-port FIFOs.
// Header byte layout: destination address in [1:0], payload length in [7:2].
package router_pkg;

    localparam int ROUTER_FIFO_DEPTH = 16;
    localparam int ROUTER_DATA_W     = 8;
    localparam int ROUTER_PTR_W      = $clog2(ROUTER_FIFO_DEPTH) + 1;

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    // FIFO entries are one bit wider than a byte; the extra bit marks a header
    localparam int HDR_TAG_BIT = ROUTER_DATA_W;

    typedef struct packed {
        logic [HDR_LEN_MSB-HDR_LEN_LSB:0]   len;
        logic [HDR_ADDR_MSB-HDR_ADDR_LSB:0] addr;
    } hdr_t;

endpackage

// File: rtl/router_fifo_if.sv
// Write/read/flush port of one router output FIFO; master is the router core side.
interface router_fifo_if #(
    parameter int WIDTH = router_pkg::ROUTER_DATA_W
);
    logic             soft_reset;
    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;

    modport master (
        output soft_reset, write_enb, read_enb, lfd_state, data_in,
        input  data_out, full, empty
    );

    modport slave (
        input  soft_reset, write_enb, read_enb, lfd_state, data_in,
        output data_out, full, empty
    );
endinterface

// File: rtl/router_fifo.sv
// Per-port packet FIFO: data_out valid 1 cycle after a read, returns to 0 after a packet's parity.
// Writes while full and reads while empty are dropped; no other backpressure.
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = ROUTER_FIFO_DEPTH,
    parameter int WIDTH = ROUTER_DATA_W
) (
    input  logic          clock,
    input  logic          reset,
    router_fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]    PTR_ONE = PW'(1);
    localparam logic [WIDTH-2:0] CNT_ONE = (WIDTH-1)'(1);

    logic [WIDTH:0]   mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-2:0] pkt_cnt;
    logic [WIDTH-1:0] data_q;

    logic             full;
    logic             empty;
    logic             do_wr;
    logic             do_rd;
    logic [WIDTH:0]   rd_entry;
    logic [WIDTH-2:0] hdr_cnt;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign do_wr = bus.write_enb && !full;
    assign do_rd = bus.read_enb && !empty;

    assign rd_entry = mem[rd_ptr[AW-1:0]];
    // Header length counts payload bytes; +1 also covers the trailing parity byte
    assign hdr_cnt  = {1'b0, rd_entry[WIDTH-1:HDR_LEN_LSB]} + CNT_ONE;

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.data_out = data_q;

    always_ff @(posedge clock) begin
        if (do_wr && !bus.soft_reset) begin
            mem[wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pkt_cnt <= '0;
            data_q  <= '0;
        end else if (bus.soft_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pkt_cnt <= '0;
            data_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                data_q <= rd_entry[WIDTH-1:0];
                if (rd_entry[WIDTH]) begin
                    pkt_cnt <= hdr_cnt;
                end else if (pkt_cnt != '0) begin
                    pkt_cnt <= pkt_cnt - CNT_ONE;
                end
            end else if (pkt_cnt == '0) begin
                // Packet fully drained: idle the output bus at zero
                data_q <= '0;
            end
        end
    end

endmodule
